// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared opcode/state types and constants for the alu593 core
package tinyalu_pkg;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_MUL  = 3'b100,
    ALU_ILL5 = 3'b101,
    ALU_ILL6 = 3'b110,
    ALU_RST  = 3'b111
  } alu_opcode_t;

  localparam logic [7:0] HALT_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IU_IDLE,
    IU_FETCH_OP,
    IU_FETCH_A,
    IU_FETCH_B,
    IU_EXEC,
    IU_WAIT_ALU,
    IU_STORE,
    IU_HALTED
  } iu_state_t;

  // Only the arithmetic/logic opcodes produce a result that is written back.
  function automatic logic op_stores(input alu_opcode_t op);
    return (op inside {ALU_ADD, ALU_AND, ALU_XOR, ALU_MUL});
  endfunction

endpackage

// File: rtl/ALU593.sv
// rtl/ALU593.sv - 8-bit ALU with single-cycle logic ops and a 3-cycle multiply
module ALU593
  import tinyalu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  alu_opcode_t op,
  output logic        done,
  output logic        error,
  output logic [15:0] alu_result
);

  logic       busy;
  logic [1:0] cnt;
  logic [7:0] a_q;
  logic [7:0] b_q;

  // Operation sequencing: short ops finish on the cycle after start, multiply counts down two more.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      cnt        <= 2'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      alu_result <= 16'd0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (busy) begin
        if (cnt == 2'd1) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          alu_result <= {8'd0, a_q} * {8'd0, b_q};
        end
        cnt <= cnt - 2'd1;
      end else if (start) begin
        a_q <= A;
        b_q <= B;
        case (op)
          ALU_ADD: begin
            done       <= 1'b1;
            alu_result <= {7'd0, {1'b0, A} + {1'b0, B}};
          end
          ALU_AND: begin
            done       <= 1'b1;
            alu_result <= {8'd0, A & B};
          end
          ALU_XOR: begin
            done       <= 1'b1;
            alu_result <= {8'd0, A ^ B};
          end
          ALU_MUL: begin
            busy <= 1'b1;
            cnt  <= 2'd2;
          end
          ALU_RST: begin
            done       <= 1'b1;
            alu_result <= 16'd0;
          end
          ALU_ILL5, ALU_ILL6: begin
            done  <= 1'b1;
            error <= 1'b1;
          end
          default: done <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/instructionUnit.sv
// rtl/instructionUnit.sv - fetch/execute/store sequencer driving the ALU and memory interface
module instructionUnit
  import tinyalu_pkg::*;
#(
  parameter logic [13:0] PROG_BASE = 14'h0000,
  parameter logic [13:0] RES_BASE  = 14'h2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        done,
  input  logic [15:0] alu_result,
  input  logic [7:0]  datatoinst,
  input  logic        mem_done,
  output logic        start,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output alu_opcode_t op,
  output logic        load,
  output logic        store,
  output logic [13:0] addr,
  output logic [15:0] result
);

  iu_state_t   state, state_d;
  logic        pending;
  logic [13:0] pc;
  logic [13:0] rp;

  assign result = alu_result;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IU_IDLE;
    else          state <= state_d;
  end

  // Next state and request pulses; a request is pulsed only while nothing is outstanding.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    load    = 1'b0;
    store   = 1'b0;
    addr    = pc;
    case (state)
      IU_IDLE: state_d = IU_FETCH_OP;
      IU_FETCH_OP: begin
        load = !pending;
        if (mem_done) state_d = (datatoinst == HALT_BYTE) ? IU_HALTED : IU_FETCH_A;
      end
      IU_FETCH_A: begin
        load = !pending;
        if (mem_done) state_d = IU_FETCH_B;
      end
      IU_FETCH_B: begin
        load = !pending;
        if (mem_done) state_d = (op == ALU_NOP) ? IU_FETCH_OP : IU_EXEC;
      end
      IU_EXEC: begin
        start   = 1'b1;
        state_d = IU_WAIT_ALU;
      end
      IU_WAIT_ALU: begin
        if (done) state_d = op_stores(op) ? IU_STORE : IU_FETCH_OP;
      end
      IU_STORE: begin
        addr  = rp;
        store = !pending;
        if (mem_done) state_d = IU_FETCH_OP;
      end
      IU_HALTED: state_d = IU_HALTED;
      default:   state_d = IU_IDLE;
    endcase
  end

  // Pointers, operand capture and outstanding-request tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      pc      <= 14'd0;
      rp      <= 14'd0;
      op      <= ALU_NOP;
      A       <= 8'd0;
      B       <= 8'd0;
    end else begin
      if (mem_done)           pending <= 1'b0;
      else if (load || store) pending <= 1'b1;
      if (state == IU_IDLE) begin
        pc <= PROG_BASE;
        rp <= RES_BASE;
      end
      if (mem_done) begin
        case (state)
          IU_FETCH_OP: if (datatoinst != HALT_BYTE) begin
            op <= alu_opcode_t'(datatoinst[2:0]);
            pc <= pc + 14'd1;
          end
          IU_FETCH_A: begin
            A  <= datatoinst;
            pc <= pc + 14'd1;
          end
          IU_FETCH_B: begin
            B  <= datatoinst;
            pc <= pc + 14'd1;
          end
          IU_STORE: rp <= rp + 14'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/memInerf.sv
// rtl/memInerf.sv - single-outstanding request/response bridge to the SRAM port
module memInerf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        store,
  input  logic [13:0] addr,
  input  logic [15:0] result,
  input  logic        mem_resp,
  input  logic [7:0]  datafrommem,
  output logic        read_req,
  output logic        write_req,
  output logic [13:0] addrout,
  output logic [15:0] datatomem,
  output logic [7:0]  datatoinst,
  output logic        mem_done
);

  // Issue a request from an idle state, hold it until the SRAM responds, then pulse mem_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_req   <= 1'b0;
      write_req  <= 1'b0;
      addrout    <= 14'd0;
      datatomem  <= 16'd0;
      datatoinst <= 8'd0;
      mem_done   <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      if (!read_req && !write_req) begin
        if (load) begin
          read_req <= 1'b1;
          addrout  <= addr;
        end else if (store) begin
          write_req <= 1'b1;
          addrout   <= addr;
          datatomem <= result;
        end
      end else if (mem_resp) begin
        if (read_req) datatoinst <= datafrommem;
        read_req  <= 1'b0;
        write_req <= 1'b0;
        mem_done  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu593_iu_mif_core.sv
// rtl/alu593_iu_mif_core.sv - core top joining the ALU, instruction unit and memory interface
module alu593_iu_mif_core
  import tinyalu_pkg::*;
#(
  parameter logic [13:0] PROG_BASE = 14'h0000,
  parameter logic [13:0] RES_BASE  = 14'h2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_resp,
  input  logic [7:0]  datafrommem,
  output logic        read_req,
  output logic        write_req,
  output logic [13:0] addrout,
  output logic [15:0] datatomem,
  output logic        error
);

  logic        start;
  logic        done;
  logic [7:0]  a;
  logic [7:0]  b;
  alu_opcode_t op;
  logic [15:0] alu_result;
  logic        load;
  logic        store;
  logic [13:0] addr;
  logic [15:0] result;
  logic [7:0]  datatoinst;
  logic        mem_done;

  ALU593 u_alu (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .A          (a),
    .B          (b),
    .op         (op),
    .done       (done),
    .error      (error),
    .alu_result (alu_result)
  );

  instructionUnit #(
    .PROG_BASE (PROG_BASE),
    .RES_BASE  (RES_BASE)
  ) u_iu (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .alu_result (alu_result),
    .datatoinst (datatoinst),
    .mem_done   (mem_done),
    .start      (start),
    .A          (a),
    .B          (b),
    .op         (op),
    .load       (load),
    .store      (store),
    .addr       (addr),
    .result     (result)
  );

  memInerf u_mif (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .store       (store),
    .addr        (addr),
    .result      (result),
    .mem_resp    (mem_resp),
    .datafrommem (datafrommem),
    .read_req    (read_req),
    .write_req   (write_req),
    .addrout     (addrout),
    .datatomem   (datatomem),
    .datatoinst  (datatoinst),
    .mem_done    (mem_done)
  );

endmodule

// File: tb/tb_alu593_iu_mif_core.sv
// tb/tb_alu593_iu_mif_core.sv - randomized and directed bench against a program-level model
module tb_alu593_iu_mif_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_resp;
  logic [7:0]  datafrommem;
  logic        read_req;
  logic        write_req;
  logic [13:0] addrout;
  logic [15:0] datatomem;
  logic        error;

  alu593_iu_mif_core dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_resp    (mem_resp),
    .datafrommem (datafrommem),
    .read_req    (read_req),
    .write_req   (write_req),
    .addrout     (addrout),
    .datatomem   (datatomem),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem [0:16383];
  logic [7:0]  prog [$];
  int          lat_cur = 0;

  logic [13:0] wr_a [$];
  logic [15:0] wr_d [$];
  int rd_cnt, err_cnt, unstable, max_lat;

  int exp_a [$];
  int exp_d [$];
  int exp_err, exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // SRAM responder and activity log (sole owner of the log variables).
  initial begin
    int          wcnt, cyc_n, t_start;
    logic        active, s_wr;
    logic [13:0] s_addr;
    logic [15:0] s_data;
    mem_resp = 1'b0;
    datafrommem = 8'd0;
    wcnt = 0; cyc_n = 0; t_start = 0; active = 1'b0;
    s_wr = 1'b0; s_addr = '0; s_data = '0;
    rd_cnt = 0; err_cnt = 0; unstable = 0; max_lat = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (!reset_n) begin
        mem_resp = 1'b0; active = 1'b0; wcnt = 0;
        wr_a.delete(); wr_d.delete();
        rd_cnt = 0; err_cnt = 0; unstable = 0; max_lat = 0;
      end else begin
        if (error) err_cnt++;
        if (dut.start) t_start = cyc_n;
        if (dut.done && (cyc_n - t_start) > max_lat) max_lat = cyc_n - t_start;
        if (mem_resp) begin
          mem_resp = 1'b0;
        end else if (read_req || write_req) begin
          if (read_req && write_req) unstable++;
          if (!active) begin
            active = 1'b1; s_addr = addrout; s_data = datatomem; s_wr = write_req; wcnt = 0;
          end else if (addrout !== s_addr || write_req !== s_wr || (s_wr && datatomem !== s_data)) begin
            unstable++;
          end
          if (wcnt >= lat_cur) begin
            mem_resp = 1'b1;
            active = 1'b0;
            if (write_req) begin
              wr_a.push_back(addrout);
              wr_d.push_back(datatomem);
            end else begin
              datafrommem = mem[addrout];
              rd_cnt++;
            end
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Program-level reference: walk the byte program and list every write the core must make.
  task automatic model();
    int pc, rp, a, b, v;
    logic [7:0] opb;
    pc = 0; rp = 'h2000;
    exp_a.delete(); exp_d.delete(); exp_err = 0; exp_rd = 0;
    while (1) begin
      opb = prog[pc];
      exp_rd++;
      if (opb == 8'hFF) break;
      a = int'(prog[pc+1]); b = int'(prog[pc+2]);
      exp_rd += 2;
      v = -1;
      case (opb[2:0])
        3'd1: v = a + b;
        3'd2: v = a & b;
        3'd3: v = a ^ b;
        3'd4: v = a * b;
        3'd5, 3'd6: exp_err++;
        default: ;
      endcase
      if (v >= 0) begin
        exp_a.push_back(rp);
        exp_d.push_back(v);
        rp++;
      end
      pc += 3;
    end
  endtask

  task automatic start_prog(input int lat);
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    foreach (prog[i]) mem[i] = prog[i];
    model();
    reset_n = 1'b0;
    lat_cur = lat;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_prog(input string name);
    int cyc, idle;
    reset_n = 1'b1;
    cyc = 0;
    while (!read_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_first_rd_lat", name), 32'(cyc <= 2), 1);
    check($sformatf("%s_first_rd_addr", name), 32'(addrout), 0);
    cyc = 0; idle = 0;
    while (idle < 30 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (read_req || write_req || mem_resp) idle = 0;
      else idle++;
    end
    check($sformatf("%s_halt_in_time", name), 32'(cyc < 5000), 1);
    check($sformatf("%s_nwrites", name), wr_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++) begin
      check($sformatf("%s_waddr%0d", name, i), 32'(wr_a[i]), exp_a[i]);
      check($sformatf("%s_wdata%0d", name, i), 32'(wr_d[i]), exp_d[i]);
    end
    check($sformatf("%s_errors", name), err_cnt, exp_err);
    check($sformatf("%s_reads", name), rd_cnt, exp_rd);
    check($sformatf("%s_stable", name), unstable, 0);
  endtask

  task automatic run_prog(input string name, input int lat);
    start_prog(lat);
    finish_prog(name);
  endtask

  initial begin
    int cyc, n;
    logic [7:0] opb;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_req_err", {29'd0, read_req, write_req, error}, 0);
    check("rst_addr", 32'(addrout), 0);
    check("rst_data", 32'(datatomem), 0);

    prog = '{8'h01, 8'h12, 8'h34, 8'hFF};
    run_prog("add", 0);
    check("add_value", 32'(wr_d.size() > 0 ? wr_d[0] : 16'h0), 32'h0046);
    check("add_alu_lat", max_lat, 1);

    prog = '{8'h04, 8'hFF, 8'hFF, 8'h03, 8'hF0, 8'h0F, 8'hFF};
    run_prog("mul", 0);
    check("mul_alu_lat", max_lat, 3);
    run_prog("mul_lat4", 4);

    prog = '{8'h05, 8'h01, 8'h01, 8'h02, 8'hF0, 8'h3C, 8'hFF};
    run_prog("illegal", 0);
    run_prog("illegal_lat4", 4);

    prog = '{8'h00, 8'h11, 8'h22, 8'h07, 8'h01, 8'h02, 8'h01, 8'h80, 8'h80, 8'hFF};
    run_prog("nop_rst", 1);

    for (int r = 0; r < 8; r++) begin
      prog.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        opb = 8'($urandom_range(0, 255));
        if (opb == 8'hFF) opb = 8'h04;
        prog.push_back(opb);
        prog.push_back(8'($urandom_range(0, 255)));
        prog.push_back(8'($urandom_range(0, 255)));
      end
      prog.push_back(8'hFF);
      run_prog($sformatf("rand%0d", r), $urandom_range(0, 3));
    end

    prog = '{8'h04, 8'hFF, 8'hFF, 8'hFF};
    start_prog(0);
    reset_n = 1'b1;
    cyc = 0;
    while (!dut.start && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmul_reached_exec", 32'(cyc < 200), 1);
    @(negedge clk);
    check("rstmul_no_write_before", wr_a.size(), 0);
    reset_n = 1'b0;
    #1;
    check("rstmul_req_drop", {30'd0, read_req, write_req}, 0);
    repeat (2) @(negedge clk);
    finish_prog("rstmul");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
